// File: rtl/sched_pkg.sv
// Shared opcode constants, scheduler state and per-instruction decode for the dual-issue scheduler.
package sched_pkg;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] J     = 6'h02;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05;
    localparam logic [5:0] ADDI  = 6'h08;
    localparam logic [5:0] ADDIU = 6'h09;
    localparam logic [5:0] SLTI  = 6'h0A;
    localparam logic [5:0] SLTIU = 6'h0B;
    localparam logic [5:0] ANDI  = 6'h0C;
    localparam logic [5:0] ORI   = 6'h0D;
    localparam logic [5:0] XORI  = 6'h0E;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;

    typedef enum logic [1:0] {EMPTY, PAIR, SINGLE} state_t;

    // rs/rt carry the source register numbers so hazard checks need only this struct
    typedef struct packed {
        logic       regwrite;
        logic [4:0] dest;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       is_mem;
        logic       is_ctrl;
    } instr_info_t;

    function automatic instr_info_t decode_info(input logic [31:0] instr);
        instr_info_t info;
        logic [5:0]  op;
        logic        writes;
        op      = instr[31:26];
        info    = '0;
        info.rs = instr[25:21];
        info.rt = instr[20:16];
        case (op)
            RTYPE, LW, ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU: writes = 1'b1;
            default:                                             writes = 1'b0;
        endcase
        info.dest     = (op == RTYPE) ? instr[15:11] : instr[20:16];
        info.regwrite = writes && (info.dest != 5'd0);
        info.uses_rs  = (op != J);
        info.uses_rt  = (op == RTYPE) || (op == SW) || (op == BEQ) || (op == BNE);
        info.is_mem   = (op == LW) || (op == SW);
        info.is_ctrl  = (op == BEQ) || (op == BNE) || (op == J);
        return info;
    endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational intra-pair (RAW/WAW/structural) and load-use hazard check for the held pair.
module pair_hazard_check
    import sched_pkg::*;
(
    input  instr_info_t info0,
    input  instr_info_t info1,
    input  logic        lu_valid,
    input  logic [4:0]  lu_dest,
    output logic        dual_ok,
    output logic        lu_hazard0,
    output logic        lu_hazard1
);

    function automatic logic reads_reg(input instr_info_t i, input logic [4:0] r);
        return (i.uses_rs && (i.rs == r)) || (i.uses_rt && (i.rt == r));
    endfunction

    logic raw;
    logic waw;
    logic unused_ok;

    assign lu_hazard0 = lu_valid && (lu_dest != 5'd0) && reads_reg(info0, lu_dest);
    assign lu_hazard1 = lu_valid && (lu_dest != 5'd0) && reads_reg(info1, lu_dest);

    assign raw = info0.regwrite && reads_reg(info1, info0.dest);
    assign waw = info0.regwrite && info1.regwrite && (info0.dest == info1.dest);

    assign dual_ok = !info1.is_mem && !info1.is_ctrl && !info0.is_ctrl &&
                     !raw && !waw && !lu_hazard0 && !lu_hazard1;

    assign unused_ok = &{1'b0, info0.is_mem};

endmodule

// File: rtl/dual_issue_scheduler.sv
// Two-entry issue buffer: dispatches a fetched pair to pipes A/B together or in order, with load-use bubbles.
module dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int IW   = 32,
    parameter int PCW  = 32,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [IW-1:0]   fetch_instr0,
    input  logic [IW-1:0]   fetch_instr1,
    input  logic [PCW-1:0]  fetch_pc,
    input  logic            stall_d,
    input  logic            flush,
    output logic            issue_a_valid,
    output logic [IW-1:0]   issue_a_instr,
    output logic [PCW-1:0]  issue_a_pc,
    output logic            issue_b_valid,
    output logic [IW-1:0]   issue_b_instr,
    output logic [PCW-1:0]  issue_b_pc,
    output logic [CNTW-1:0] dual_cnt,
    output logic [CNTW-1:0] bubble_cnt
);

    state_t         state;
    logic [IW-1:0]  slot0_instr;
    logic [IW-1:0]  slot1_instr;
    logic [PCW-1:0] pair_pc;

    instr_info_t info0;
    instr_info_t info1;
    logic        lu_valid;
    logic [4:0]  lu_dest;
    logic        dual_ok;
    logic        lu_hazard0;
    logic        lu_hazard1;
    logic        drain;
    logic        capture;

    assign info0 = decode_info(slot0_instr);
    assign info1 = decode_info(slot1_instr);

    // The load-use tracker is the LW sitting in issue_a; it clears whenever issue_a_valid drops
    assign lu_valid = issue_a_valid && (issue_a_instr[31:26] == LW);
    assign lu_dest  = issue_a_instr[20:16];

    pair_hazard_check u_hazard (
        .info0      (info0),
        .info1      (info1),
        .lu_valid   (lu_valid),
        .lu_dest    (lu_dest),
        .dual_ok    (dual_ok),
        .lu_hazard0 (lu_hazard0),
        .lu_hazard1 (lu_hazard1)
    );

    assign drain       = ((state == PAIR) && dual_ok) || ((state == SINGLE) && !lu_hazard1);
    assign fetch_ready = !flush && !stall_d && ((state == EMPTY) || drain);
    assign capture     = fetch_valid && fetch_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= EMPTY;
            slot0_instr   <= '0;
            slot1_instr   <= '0;
            pair_pc       <= '0;
            issue_a_valid <= 1'b0;
            issue_a_instr <= '0;
            issue_a_pc    <= '0;
            issue_b_valid <= 1'b0;
            issue_b_instr <= '0;
            issue_b_pc    <= '0;
            dual_cnt      <= '0;
            bubble_cnt    <= '0;
        end else if (flush) begin
            state         <= EMPTY;
            issue_a_valid <= 1'b0;
            issue_b_valid <= 1'b0;
        end else if (!stall_d) begin
            issue_a_valid <= 1'b0;
            issue_b_valid <= 1'b0;
            case (state)
                PAIR: begin
                    if (lu_hazard0) begin
                        bubble_cnt <= bubble_cnt + CNTW'(1);
                    end else begin
                        issue_a_valid <= 1'b1;
                        issue_a_instr <= slot0_instr;
                        issue_a_pc    <= pair_pc;
                        if (dual_ok) begin
                            issue_b_valid <= 1'b1;
                            issue_b_instr <= slot1_instr;
                            issue_b_pc    <= pair_pc + PCW'(4);
                            dual_cnt      <= dual_cnt + CNTW'(1);
                        end else begin
                            state <= SINGLE;
                        end
                    end
                end
                SINGLE: begin
                    if (lu_hazard1) begin
                        bubble_cnt <= bubble_cnt + CNTW'(1);
                    end else begin
                        issue_a_valid <= 1'b1;
                        issue_a_instr <= slot1_instr;
                        issue_a_pc    <= pair_pc + PCW'(4);
                    end
                end
                default: ;
            endcase
            // capture only occurs when the buffer is empty or fully drains, so it never races PAIR->SINGLE
            if (capture) begin
                state       <= PAIR;
                slot0_instr <= fetch_instr0;
                slot1_instr <= fetch_instr1;
                pair_pc     <= fetch_pc;
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_dual_issue_scheduler;

    localparam logic [5:0] T_RTYPE = 6'h00;
    localparam logic [5:0] T_J     = 6'h02;
    localparam logic [5:0] T_BEQ   = 6'h04;
    localparam logic [5:0] T_BNE   = 6'h05;
    localparam logic [5:0] T_ADDI  = 6'h08;
    localparam logic [5:0] T_ADDIU = 6'h09;
    localparam logic [5:0] T_SLTI  = 6'h0A;
    localparam logic [5:0] T_SLTIU = 6'h0B;
    localparam logic [5:0] T_ANDI  = 6'h0C;
    localparam logic [5:0] T_ORI   = 6'h0D;
    localparam logic [5:0] T_XORI  = 6'h0E;
    localparam logic [5:0] T_LW    = 6'h23;
    localparam logic [5:0] T_SW    = 6'h2B;

    logic        clk;
    logic        reset_n;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr0;
    logic [31:0] fetch_instr1;
    logic [31:0] fetch_pc;
    logic        stall_d;
    logic        flush;
    logic        issue_a_valid;
    logic [31:0] issue_a_instr;
    logic [31:0] issue_a_pc;
    logic        issue_b_valid;
    logic [31:0] issue_b_instr;
    logic [31:0] issue_b_pc;
    logic [31:0] dual_cnt;
    logic [31:0] bubble_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    dual_issue_scheduler #(.IW(32), .PCW(32), .CNTW(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_instr0  (fetch_instr0),
        .fetch_instr1  (fetch_instr1),
        .fetch_pc      (fetch_pc),
        .stall_d       (stall_d),
        .flush         (flush),
        .issue_a_valid (issue_a_valid),
        .issue_a_instr (issue_a_instr),
        .issue_a_pc    (issue_a_pc),
        .issue_b_valid (issue_b_valid),
        .issue_b_instr (issue_b_instr),
        .issue_b_pc    (issue_b_pc),
        .dual_cnt      (dual_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: queue of held instructions ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        held[$];
    bit          ea_v, eb_v;
    logic [31:0] ea_i, ea_pc, eb_i, eb_pc;
    logic [31:0] e_dual, e_bubble;
    int          lw_dest = -1;

    function automatic int dest_of(logic [31:0] i);
        case (i[31:26])
            T_RTYPE: return int'(i[15:11]);
            T_LW, T_ADDI, T_ADDIU, T_ANDI, T_ORI, T_XORI, T_SLTI, T_SLTIU: return int'(i[20:16]);
            default: return 0;
        endcase
    endfunction

    function automatic bit reads(logic [31:0] i, int r);
        logic [5:0] op;
        bit rs_used, rt_used;
        op = i[31:26];
        if (r <= 0) return 1'b0;
        rs_used = (op != T_J);
        rt_used = (op == T_RTYPE) || (op == T_SW) || (op == T_BEQ) || (op == T_BNE);
        return (rs_used && int'(i[25:21]) == r) || (rt_used && int'(i[20:16]) == r);
    endfunction

    function automatic bit is_mem(logic [31:0] i);
        return (i[31:26] == T_LW) || (i[31:26] == T_SW);
    endfunction

    function automatic bit is_ctrl(logic [31:0] i);
        return (i[31:26] == T_BEQ) || (i[31:26] == T_BNE) || (i[31:26] == T_J);
    endfunction

    function automatic bit pair_ok(logic [31:0] i0, logic [31:0] i1);
        int d0, d1;
        d0 = dest_of(i0);
        d1 = dest_of(i1);
        return !is_mem(i1) && !is_ctrl(i1) && !is_ctrl(i0) && !reads(i1, d0) &&
               !(d0 != 0 && d0 == d1) && !reads(i0, lw_dest) && !reads(i1, lw_dest);
    endfunction

    function automatic bit m_ready();
        if (flush || stall_d) return 1'b0;
        if (held.size() == 0) return 1'b1;
        if (reads(held[0].instr, lw_dest)) return 1'b0;
        if (held.size() == 1) return 1'b1;
        return pair_ok(held[0].instr, held[1].instr);
    endfunction

    function automatic void model_edge();
        bit rdy;
        rdy = m_ready();
        if (!reset_n) begin
            held.delete();
            ea_v = 0; eb_v = 0;
            ea_i = '0; ea_pc = '0; eb_i = '0; eb_pc = '0;
            e_dual = '0; e_bubble = '0;
            lw_dest = -1;
        end else if (flush) begin
            held.delete();
            ea_v = 0; eb_v = 0;
            lw_dest = -1;
        end else if (!stall_d) begin
            ea_v = 0; eb_v = 0;
            if (held.size() > 0) begin
                if (reads(held[0].instr, lw_dest)) begin
                    e_bubble = e_bubble + 1;
                end else begin
                    ea_v = 1; ea_i = held[0].instr; ea_pc = held[0].pc;
                    if (held.size() == 2 && pair_ok(held[0].instr, held[1].instr)) begin
                        eb_v = 1; eb_i = held[1].instr; eb_pc = held[1].pc;
                        e_dual = e_dual + 1;
                        void'(held.pop_front());
                    end
                    void'(held.pop_front());
                end
            end
            lw_dest = (ea_v && ea_i[31:26] == T_LW) ? int'(ea_i[20:16]) : -1;
            if (fetch_valid && rdy) begin
                held.push_back('{instr: fetch_instr0, pc: fetch_pc});
                held.push_back('{instr: fetch_instr1, pc: fetch_pc + 32'd4});
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; fetch_valid = 1'b0; flush = 1'b0; stall_d = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic drive_pair(logic [31:0] i0, logic [31:0] i1, logic [31:0] pc);
        fetch_valid = 1'b1; fetch_instr0 = i0; fetch_instr1 = i1; fetch_pc = pc;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; stall_d = 1'b0;
        drive_pair(32'h00221820, 32'h20A40001, 32'h100);
        step();
        step();
        reset_n = 1'b1; fetch_valid = 1'b0;
        #1;
        n_cmp++; if ({issue_a_valid, issue_a_instr, issue_a_pc} !== 65'd0) begin n_bad++; $display("FAIL reset_a got %h want 0", {issue_a_valid, issue_a_instr, issue_a_pc}); end
        n_cmp++; if ({issue_b_valid, issue_b_instr, issue_b_pc} !== 65'd0) begin n_bad++; $display("FAIL reset_b got %h want 0", {issue_b_valid, issue_b_instr, issue_b_pc}); end
        n_cmp++; if ({dual_cnt, bubble_cnt} !== 64'd0) begin n_bad++; $display("FAIL reset_cnt got %h want 0", {dual_cnt, bubble_cnt}); end
        n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", fetch_ready); end
    endtask

    task automatic test_independent_pair();
        apply_reset();
        drive_pair(32'h00221820, 32'h20A40001, 32'h100);
        step();
        fetch_valid = 1'b0;
        #1;
        n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL indep_ready got %b want 1", fetch_ready); end
        step();
        n_cmp++; if ({issue_a_valid, issue_a_instr, issue_a_pc} !== {1'b1, 32'h00221820, 32'h100}) begin n_bad++; $display("FAIL indep_a got %h want %h", {issue_a_valid, issue_a_instr, issue_a_pc}, {1'b1, 32'h00221820, 32'h100}); end
        n_cmp++; if ({issue_b_valid, issue_b_instr, issue_b_pc} !== {1'b1, 32'h20A40001, 32'h104}) begin n_bad++; $display("FAIL indep_b got %h want %h", {issue_b_valid, issue_b_instr, issue_b_pc}, {1'b1, 32'h20A40001, 32'h104}); end
        n_cmp++; if (dual_cnt !== 32'd1) begin n_bad++; $display("FAIL indep_dual got %0d want 1", dual_cnt); end
    endtask

    task automatic test_raw_pair();
        apply_reset();
        drive_pair(32'h00221820, 32'h00632020, 32'h100);
        step();
        fetch_valid = 1'b0;
        #1;
        n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL raw_ready_pair got %b want 0", fetch_ready); end
        step();
        n_cmp++; if ({issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid} !== {1'b1, 32'h00221820, 32'h100, 1'b0}) begin n_bad++; $display("FAIL raw_first got %h want %h", {issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid}, {1'b1, 32'h00221820, 32'h100, 1'b0}); end
        step();
        n_cmp++; if ({issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid} !== {1'b1, 32'h00632020, 32'h104, 1'b0}) begin n_bad++; $display("FAIL raw_second got %h want %h", {issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid}, {1'b1, 32'h00632020, 32'h104, 1'b0}); end
        n_cmp++; if (dual_cnt !== 32'd0) begin n_bad++; $display("FAIL raw_dual got %0d want 0", dual_cnt); end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive_pair(32'h8C220000, 32'h00000000, 32'h200);
        step();
        drive_pair(32'h00422020, 32'h00000000, 32'h208);
        step();
        fetch_valid = 1'b0;
        #1;
        n_cmp++; if ({issue_a_valid, issue_a_instr, issue_b_valid} !== {1'b1, 32'h8C220000, 1'b1}) begin n_bad++; $display("FAIL lu_lw_issue got %h want %h", {issue_a_valid, issue_a_instr, issue_b_valid}, {1'b1, 32'h8C220000, 1'b1}); end
        n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL lu_ready got %b want 0", fetch_ready); end
        step();
        n_cmp++; if ({issue_a_valid, issue_b_valid, bubble_cnt} !== {2'b00, 32'd1}) begin n_bad++; $display("FAIL lu_bubble got %h want %h", {issue_a_valid, issue_b_valid, bubble_cnt}, {2'b00, 32'd1}); end
        step();
        n_cmp++; if ({issue_a_valid, issue_a_instr, issue_a_pc} !== {1'b1, 32'h00422020, 32'h208}) begin n_bad++; $display("FAIL lu_after got %h want %h", {issue_a_valid, issue_a_instr, issue_a_pc}, {1'b1, 32'h00422020, 32'h208}); end
        n_cmp++; if (bubble_cnt !== 32'd1) begin n_bad++; $display("FAIL lu_bubble_hold got %0d want 1", bubble_cnt); end
    endtask

    task automatic test_branch_flush();
        apply_reset();
        drive_pair(32'h10220003, 32'h20A40001, 32'h300);
        step();
        fetch_valid = 1'b0;
        step();
        n_cmp++; if ({issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid} !== {1'b1, 32'h10220003, 32'h300, 1'b0}) begin n_bad++; $display("FAIL br_alone got %h want %h", {issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid}, {1'b1, 32'h10220003, 32'h300, 1'b0}); end
        flush = 1'b1;
        drive_pair(32'h00221820, 32'h20A40001, 32'h400);
        #1;
        n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL br_flush_ready got %b want 0", fetch_ready); end
        step();
        flush = 1'b0; fetch_valid = 1'b0;
        n_cmp++; if ({issue_a_valid, issue_b_valid} !== 2'b00) begin n_bad++; $display("FAIL br_flush_valid got %b want 00", {issue_a_valid, issue_b_valid}); end
        #1;
        n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL br_empty_ready got %b want 1", fetch_ready); end
        step();
        n_cmp++; if ({issue_a_valid, issue_b_valid} !== 2'b00) begin n_bad++; $display("FAIL br_discarded got %b want 00", {issue_a_valid, issue_b_valid}); end
    endtask

    task automatic test_stall();
        apply_reset();
        drive_pair(32'h00221820, 32'h20A40001, 32'h100);
        step();
        drive_pair(32'h00A63820, 32'h35080005, 32'h108);
        step();
        stall_d = 1'b1;
        drive_pair(32'h00221820, 32'h20A40001, 32'h110);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d] got %b want 0", i, fetch_ready); end
            step();
            n_cmp++; if ({issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid, issue_b_instr, issue_b_pc, dual_cnt} !== {1'b1, 32'h00221820, 32'h100, 1'b1, 32'h20A40001, 32'h104, 32'd1}) begin n_bad++; $display("FAIL stall_hold[%0d] got %h", i, {issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid, issue_b_instr, issue_b_pc, dual_cnt}); end
        end
        stall_d = 1'b0; fetch_valid = 1'b0;
        step();
        n_cmp++; if ({issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid, issue_b_instr, issue_b_pc, dual_cnt} !== {1'b1, 32'h00A63820, 32'h108, 1'b1, 32'h35080005, 32'h10C, 32'd2}) begin n_bad++; $display("FAIL stall_resume got %h", {issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid, issue_b_instr, issue_b_pc, dual_cnt}); end
    endtask

    task automatic test_reset_in_single();
        apply_reset();
        drive_pair(32'h00221820, 32'h20A40001, 32'h100);
        step();
        drive_pair(32'h00221820, 32'h00632020, 32'h108);
        step();
        fetch_valid = 1'b0;
        step();
        n_cmp++; if ({issue_a_valid, issue_a_pc, dual_cnt} !== {1'b1, 32'h108, 32'd1}) begin n_bad++; $display("FAIL rs_pre got %h want %h", {issue_a_valid, issue_a_pc, dual_cnt}, {1'b1, 32'h108, 32'd1}); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        n_cmp++; if ({issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid, issue_b_instr, issue_b_pc} !== 130'd0) begin n_bad++; $display("FAIL rs_outputs got %h want 0", {issue_a_valid, issue_a_instr, issue_a_pc, issue_b_valid, issue_b_instr, issue_b_pc}); end
        n_cmp++; if ({dual_cnt, bubble_cnt} !== 64'd0) begin n_bad++; $display("FAIL rs_cnt got %h want 0", {dual_cnt, bubble_cnt}); end
        #1;
        n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL rs_ready got %b want 1", fetch_ready); end
    endtask

    // ---------------- randomized traffic ----------------
    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        rs = 5'($urandom_range(3));
        rt = 5'($urandom_range(3));
        rd = 5'($urandom_range(3));
        case ($urandom_range(12))
            0, 1, 2, 3: return {T_RTYPE, rs, rt, rd, 5'd0, 6'h20};
            4, 5:       return {T_LW, rs, rt, 16'($urandom)};
            6:          return {T_SW, rs, rt, 16'($urandom)};
            7:          return {T_BEQ, rs, rt, 16'($urandom)};
            8:          return {T_BNE, rs, rt, 16'($urandom)};
            9:          return {T_ADDI, rs, rt, 16'($urandom)};
            10:         return {T_J, 26'($urandom)};
            11:         return {T_ORI, rs, rt, 16'($urandom)};
            default:    return {6'h3F, rs, rt, 16'($urandom)};
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] pc;
        pc = 32'h1000;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset_n = ($urandom_range(99) != 0);
            flush   = ($urandom_range(19) == 0);
            stall_d = ($urandom_range(7) == 0);
            drive_pair(rand_instr(), rand_instr(), pc);
            fetch_valid = ($urandom_range(3) != 0);
            pc = pc + 32'd8;
            #1;
            n_cmp++; if (fetch_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, fetch_ready, m_ready()); end
            step();
            n_cmp++; if ({issue_a_valid, issue_b_valid} !== {ea_v, eb_v}) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, {issue_a_valid, issue_b_valid}, {ea_v, eb_v}); end
            if (ea_v) begin
                n_cmp++; if ({issue_a_instr, issue_a_pc} !== {ea_i, ea_pc}) begin n_bad++; $display("FAIL rnd_a cyc %0d got %h want %h", cyc, {issue_a_instr, issue_a_pc}, {ea_i, ea_pc}); end
            end
            if (eb_v) begin
                n_cmp++; if ({issue_b_instr, issue_b_pc} !== {eb_i, eb_pc}) begin n_bad++; $display("FAIL rnd_b cyc %0d got %h want %h", cyc, {issue_b_instr, issue_b_pc}, {eb_i, eb_pc}); end
            end
            n_cmp++; if ({dual_cnt, bubble_cnt} !== {e_dual, e_bubble}) begin n_bad++; $display("FAIL rnd_cnt cyc %0d got %h want %h", cyc, {dual_cnt, bubble_cnt}, {e_dual, e_bubble}); end
        end
        reset_n = 1'b1; flush = 1'b0; stall_d = 1'b0; fetch_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; fetch_valid = 1'b0; stall_d = 1'b0; flush = 1'b0;
        fetch_instr0 = '0; fetch_instr1 = '0; fetch_pc = '0;
        test_reset();
        test_independent_pair();
        test_raw_pair();
        test_load_use();
        test_branch_flush();
        test_stall();
        test_reset_in_single();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
